// File: rtl/nn_scaler_pipelined.sv
// Nearest-neighbour frame scaler: walks the destination raster, fetches the matching
// source pixel from ROM and writes it to frame RAM after the ROM latency.
module nn_scaler_pipelined #(
    parameter int SRC_W   = 160,
    parameter int SRC_H   = 120,
    parameter int PIX_W   = 8,
    parameter int ROM_LAT = 1,
    parameter int SRC_AW  = 15,
    parameter int DST_AW  = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic [SRC_AW-1:0] rom_addr,
    output logic [DST_AW-1:0] ram_addr,
    output logic              wren,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [10:0]       dst_w,
    output logic [10:0]       dst_h
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        mode_reg;
    logic [10:0]       dx_reg, dy_reg, dx_next, dy_next;
    logic [DST_AW-1:0] row_base_reg, row_base_next;
    logic [2:0]        drain_cnt_reg;
    logic [10:0]       sx_next, sy_next;
    logic [SRC_AW-1:0] rom_addr_next;
    logic [DST_AW-1:0] issue_addr;
    logic              issue_valid;
    logic              mode_valid, last_col, last_row, accept;

    // mode[2] selects decimation; mode[1:0] is the shift amount in both directions
    function automatic logic [10:0] scale_dim(input logic [10:0] s, input logic [2:0] m);
        return m[2] ? (s >> m[1:0]) : (s << m[1:0]);
    endfunction

    assign mode_valid  = (mode != 3'b100) && (mode != 3'b111);
    assign accept      = (state_reg == IDLE) && start && mode_valid;
    assign last_col    = (dx_reg == dst_w - 11'd1);
    assign last_row    = (dy_reg == dst_h - 11'd1);
    assign issue_valid = (state_reg == ISSUE);
    assign issue_addr  = row_base_reg + DST_AW'(dx_reg);
    assign busy        = (state_reg != IDLE);

    always_comb begin
        dx_next       = dx_reg + 11'd1;
        dy_next       = dy_reg;
        row_base_next = row_base_reg;
        if (last_col) begin
            dx_next       = 11'd0;
            dy_next       = dy_reg + 11'd1;
            row_base_next = row_base_reg + DST_AW'(dst_w);
        end
        sx_next       = mode_reg[2] ? (dx_next << mode_reg[1:0]) : (dx_next >> mode_reg[1:0]);
        sy_next       = mode_reg[2] ? (dy_next << mode_reg[1:0]) : (dy_next >> mode_reg[1:0]);
        rom_addr_next = SRC_AW'(32'(sy_next) * SRC_W + 32'(sx_next));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (last_col && last_row) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg == 3'(ROM_LAT)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= 3'b000;
            dx_reg        <= '0;
            dy_reg        <= '0;
            row_base_reg  <= '0;
            drain_cnt_reg <= '0;
            rom_addr      <= '0;
            dst_w         <= '0;
            dst_h         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            pixel_out     <= '0;
        end else begin
            state_reg     <= state_next;
            done          <= (state_reg == DONE);
            err           <= (state_reg == IDLE) && start && !mode_valid;
            pixel_out     <= pixel_in;
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + 3'd1 : 3'd0;
            if (accept) begin
                mode_reg     <= mode;
                dx_reg       <= '0;
                dy_reg       <= '0;
                row_base_reg <= '0;
                rom_addr     <= '0;
                dst_w        <= scale_dim(11'(SRC_W), mode);
                dst_h        <= scale_dim(11'(SRC_H), mode);
            end else if (state_reg == ISSUE) begin
                dx_reg       <= dx_next;
                dy_reg       <= dy_next;
                row_base_reg <= row_base_next;
                // hold the address after the final pixel so it never leaves the frame
                if (!(last_col && last_row)) rom_addr <= rom_addr_next;
            end
        end
    end

    // Write tag travels alongside the ROM read so the data and its address meet at the RAM
    logic [DST_AW-1:0] tag_addr_reg  [ROM_LAT+1];
    logic              tag_valid_reg [ROM_LAT+1];

    generate
        for (genvar gi = 0; gi <= ROM_LAT; gi++) begin : g_tag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_addr_reg[gi]  <= '0;
                    tag_valid_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    tag_addr_reg[gi]  <= issue_addr;
                    tag_valid_reg[gi] <= issue_valid;
                end else begin
                    tag_addr_reg[gi]  <= tag_addr_reg[gi-1];
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                end
            end
        end
    endgenerate

    assign ram_addr = tag_addr_reg[ROM_LAT];
    assign wren     = tag_valid_reg[ROM_LAT];

endmodule

// File: tb/tb_nn_scaler_pipelined.sv
// Bench for nn_scaler_pipelined: two instances (ROM latency 1 and 3) on a small source
// frame, checked against a division/multiplication model of nearest-neighbour scaling.
module tb_nn_scaler_pipelined;
    localparam int SW = 16, SH = 12, PW = 8, SAW = 8, DAW = 14;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] mode = 3'd0;

    logic [PW-1:0]  pix_a, pix_b, pout_a, pout_b;
    logic [SAW-1:0] raddr_a, raddr_b;
    logic [DAW-1:0] waddr_a, waddr_b;
    logic           wren_a, wren_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [10:0]    dw_a, dh_a, dw_b, dh_b;

    always #5 clk = ~clk;

    nn_scaler_pipelined #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .ROM_LAT(1), .SRC_AW(SAW), .DST_AW(DAW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pixel_in(pix_a),
        .rom_addr(raddr_a), .ram_addr(waddr_a), .wren(wren_a), .pixel_out(pout_a),
        .busy(busy_a), .done(done_a), .err(err_a), .dst_w(dw_a), .dst_h(dh_a));

    nn_scaler_pipelined #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .ROM_LAT(3), .SRC_AW(SAW), .DST_AW(DAW)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pixel_in(pix_b),
        .rom_addr(raddr_b), .ram_addr(waddr_b), .wren(wren_b), .pixel_out(pout_b),
        .busy(busy_b), .done(done_b), .err(err_b), .dst_w(dw_b), .dst_h(dh_b));

    // ROM models with latency 1 and 3
    logic [7:0] rom_mem [SW*SH];
    logic [7:0] dl_a;
    logic [7:0] dl_b [3];
    always @(posedge clk) begin
        dl_a    <= rom_mem[raddr_a];
        dl_b[0] <= rom_mem[raddr_b];
        dl_b[1] <= dl_b[0];
        dl_b[2] <= dl_b[1];
    end
    assign pix_a = dl_a;
    assign pix_b = dl_b[2];

    typedef struct {
        logic [2:0] m;
        bit         valid;
        int         dw;
        int         dh;
    } vec_t;
    vec_t tbl[8];

    int checks = 0, failures = 0;
    int lat[2] = '{1, 3};
    int wr_cnt[2], bad_cnt[2], done_c[2], done_n[2], err_n[2], err_c[2], busy_n[2], dim_bad[2];
    int cur_m, cur_dw, cur_dh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: destination pixel i maps to the source pixel by integer scaling
    function automatic int exp_pix(input int m, input int dw, input int i);
        int dx, dy, sx, sy, f;
        dx = i % dw;
        dy = i / dw;
        if (m < 4) begin
            f = 2 ** m;
            sx = dx / f;
            sy = dy / f;
        end else begin
            f = (m == 5) ? 2 : 4;
            sx = dx * f;
            sy = dy * f;
        end
        return int'(rom_mem[sy * SW + sx]);
    endfunction

    task automatic sample(input int d, input int c, input logic w, input logic [DAW-1:0] a,
                          input logic [7:0] p, input logic dn, input logic er, input logic bs,
                          input logic [10:0] ow, input logic [10:0] oh);
        if (w) begin
            int idx, ep;
            idx = wr_cnt[d];
            ep = exp_pix(cur_m, cur_dw, idx);
            if (int'(a) != idx || int'(p) != ep || c != lat[d] + 2 + idx) begin
                if (bad_cnt[d] < 3)
                    $display("dut%0d write %0d wrong: addr=%0d data=%0d cycle=%0d want addr=%0d data=%0d cycle=%0d",
                             d, idx, a, p, c, idx, ep, lat[d] + 2 + idx);
                bad_cnt[d]++;
            end
            wr_cnt[d]++;
        end
        if (dn) begin
            if (done_c[d] < 0) done_c[d] = c;
            done_n[d]++;
        end
        if (er) begin
            err_n[d]++;
            err_c[d] = c;
        end
        if (bs) begin
            busy_n[d]++;
            if (int'(ow) != cur_dw || int'(oh) != cur_dh) dim_bad[d]++;
        end
    endtask

    task automatic run_frame(input vec_t v, input bit poke_start);
        int n, limit;
        cur_m  = int'(v.m);
        cur_dw = v.dw;
        cur_dh = v.dh;
        n      = v.dw * v.dh;
        limit  = v.valid ? n + 10 : 20;
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; bad_cnt[d] = 0; done_c[d] = -1; done_n[d] = 0;
            err_n[d] = 0; err_c[d] = -1; busy_n[d] = 0; dim_bad[d] = 0;
        end
        @(negedge clk);
        mode  = v.m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            sample(0, c, wren_a, waddr_a, pout_a, done_a, err_a, busy_a, dw_a, dh_a);
            sample(1, c, wren_b, waddr_b, pout_b, done_b, err_b, busy_b, dw_b, dh_b);
            if (poke_start) begin
                start = (c == 40);
                mode  = (c == 40) ? 3'd3 : v.m;
            end
            if (c < limit) @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            if (v.valid) begin
                chk($sformatf("m%0d_d%0d_writes", cur_m, d), wr_cnt[d], n);
                chk($sformatf("m%0d_d%0d_bad_writes", cur_m, d), bad_cnt[d], 0);
                chk($sformatf("m%0d_d%0d_done_cycle", cur_m, d), done_c[d], n + lat[d] + 3);
                chk($sformatf("m%0d_d%0d_done_pulses", cur_m, d), done_n[d], 1);
                chk($sformatf("m%0d_d%0d_busy_cycles", cur_m, d), busy_n[d], n + lat[d] + 2);
                chk($sformatf("m%0d_d%0d_dims_bad", cur_m, d), dim_bad[d], 0);
                chk($sformatf("m%0d_d%0d_err", cur_m, d), err_n[d], 0);
            end else begin
                chk($sformatf("m%0d_d%0d_err_pulses", cur_m, d), err_n[d], 1);
                chk($sformatf("m%0d_d%0d_err_cycle", cur_m, d), err_c[d], 1);
                chk($sformatf("m%0d_d%0d_busy", cur_m, d), busy_n[d], 0);
                chk($sformatf("m%0d_d%0d_writes", cur_m, d), wr_cnt[d], 0);
                chk($sformatf("m%0d_d%0d_done", cur_m, d), done_n[d], 0);
            end
        end
        $display("frame mode=%0d dst=%0dx%0d poke=%0d writes=%0d/%0d checks=%0d failures=%0d",
                 cur_m, cur_dw, cur_dh, poke_start, wr_cnt[0], wr_cnt[1], checks, failures);
    endtask

    function automatic int outs_nonzero_a();
        return int'(|{raddr_a, waddr_a, wren_a, pout_a, busy_a, done_a, err_a, dw_a, dh_a});
    endfunction
    function automatic int outs_nonzero_b();
        return int'(|{raddr_b, waddr_b, wren_b, pout_b, busy_b, done_b, err_b, dw_b, dh_b});
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < SW * SH; i++) rom_mem[i] = 8'($urandom);
    endtask

    task automatic reset_mid_run();
        int cnt, flags;
        cnt = 0;
        @(negedge clk);
        mode  = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5000 && cnt < 500; c++) begin
            if (wren_a) cnt++;
            if (cnt < 500) @(negedge clk);
        end
        chk("rst_reached_write500", cnt, 500);
        rst = 1'b1;
        #1;
        chk("rst_outputs_a_now", outs_nonzero_a(), 0);
        chk("rst_outputs_b_now", outs_nonzero_b(), 0);
        @(negedge clk);
        flags = int'({wren_a, wren_b, busy_a, busy_b});
        chk("rst_wren_busy_next", flags, 0);
        rst = 1'b0;
        $display("reset at write %0d: wren/busy flags=%0d", cnt, flags);
    endtask

    initial begin
        tbl[0] = '{3'd0, 1'b1, 16, 12};
        tbl[1] = '{3'd1, 1'b1, 32, 24};
        tbl[2] = '{3'd2, 1'b1, 64, 48};
        tbl[3] = '{3'd3, 1'b1, 128, 96};
        tbl[4] = '{3'd5, 1'b1, 8, 6};
        tbl[5] = '{3'd6, 1'b1, 4, 3};
        tbl[6] = '{3'd4, 1'b0, 0, 0};
        tbl[7] = '{3'd7, 1'b0, 0, 0};

        fill_rom();
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", outs_nonzero_a(), 0);
        chk("reset_outputs_b", outs_nonzero_b(), 0);
        $display("reset state: nonzero_a=%0d nonzero_b=%0d", outs_nonzero_a(), outs_nonzero_b());
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(tbl[i], 1'b0);

        run_frame(tbl[1], 1'b1);

        reset_mid_run();
        run_frame(tbl[0], 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_rom();
            run_frame(tbl[$urandom_range(0, 5)], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
